// File: rtl/ucsbece154a_instr_encoder.sv
// rtl/ucsbece154a_instr_encoder.sv - RV32I field-form encoder that streams encoded words into imem
module ucsbece154a_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        kind_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [ADDR_W:0] LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic [31:0]       wd;
  logic              err;
  logic              legal;
  logic [31:0]       word;
  logic [2:0]        alu_f3;
  logic              i_ok, b_ok, j_ok, u_ok;

  // An immediate fits a signed field when every bit above the field's sign bit equals that sign bit.
  assign i_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign b_ok = ((imm_i[31:12] == '0) || (imm_i[31:12] == '1)) && !imm_i[0];
  assign j_ok = ((imm_i[31:20] == '0) || (imm_i[31:20] == '1)) && !imm_i[0];
  assign u_ok = (imm_i[11:0] == '0);

  always_comb begin
    alu_f3 = 3'b000;
    case (kind_i)
      4'd4, 4'd9:  alu_f3 = 3'b010;
      4'd5, 4'd10: alu_f3 = 3'b110;
      4'd6, 4'd11: alu_f3 = 3'b111;
      default:     alu_f3 = 3'b000;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (kind_i)
      4'd0: begin
        legal = i_ok;
        word  = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
      end
      4'd1: begin
        legal = i_ok;
        word  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
      end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        legal = 1'b1;
        word  = {((kind_i == 4'd3) ? 7'b0100000 : 7'b0000000), rs2_i, rs1_i, alu_f3, rd_i, 7'b0110011};
      end
      4'd7: begin
        legal = b_ok;
        word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000, imm_i[4:1], imm_i[11], 7'b1100011};
      end
      4'd8, 4'd9, 4'd10, 4'd11: begin
        legal = i_ok;
        word  = {imm_i[11:0], rs1_i, alu_f3, rd_i, 7'b0010011};
      end
      4'd12: begin
        legal = j_ok;
        word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
      end
      4'd13: begin
        legal = u_ok;
        word  = {imm_i[31:12], rd_i, 7'b0110111};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      addr  <= '0;
      count <= '0;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (legal) begin
              wd    <= word;
              state <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready_i) begin
            addr  <= addr + 1'b1;
            count <= count + 1'b1;
            state <= (count == LAST_COUNT) ? S_FULL : S_IDLE;
          end
        end
        S_FULL: state <= S_FULL;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == S_IDLE);
  assign mem_we_o    = (state == S_WRITE);
  assign full_o      = (state == S_FULL);
  assign mem_addr_o  = addr;
  assign mem_wd_o    = wd;
  assign count_o     = count;
  assign err_o       = err;

endmodule

// File: tb/tb_ucsbece154a_instr_encoder.sv
// tb/tb_ucsbece154a_instr_encoder.sv - scoreboard bench for the instruction encoder
module tb_ucsbece154a_instr_encoder;
  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [3:0]    kind_i = '0;
  logic [4:0]    rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [31:0]   imm_i = '0;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wd_o;
  logic          mem_ready_i = 1'b1;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;

  typedef struct {
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   m_addr = 0, m_count = 0;
  logic m_err = 1'b0;
  int   rdy_mode = 0;
  int   bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                    -1048576, 1048574, 1048576, -1048578, 0, 1};

  ucsbece154a_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_ready_i(mem_ready_i), .count_o(count_o), .full_o(full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  function automatic int fld(input logic [31:0] v, input int hi, input int lo);
    return int'((v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  // Reference assembler: range rules on the signed value, then fields placed by shift-and-or.
  function automatic void ref_encode(input int kind, input int rd, input int rs1, input int rs2,
                                     input logic [31:0] imm, output bit ok, output logic [31:0] w);
    int s, f3;
    s  = $signed(imm);
    ok = 0;
    w  = '0;
    case (kind % 5)
      0: f3 = (kind == 5) ? 6 : 0;
      1: f3 = (kind == 6) ? 7 : 0;
      2: f3 = 0;
      3: f3 = (kind == 8) ? 0 : 0;
      default: f3 = 0;
    endcase
    case (kind)
      2, 3, 8:  f3 = 0;
      4, 9:     f3 = 2;
      5, 10:    f3 = 6;
      6, 11:    f3 = 7;
      default:  f3 = 2;
    endcase
    case (kind)
      0, 1, 8, 9, 10, 11: ok = (s >= -2048) && (s <= 2047);
      2, 3, 4, 5, 6:      ok = 1;
      7:                  ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      12:                 ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
      13:                 ok = (fld(imm, 11, 0) == 0);
      default:            ok = 0;
    endcase
    case (kind)
      0: w = 32'((fld(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03);
      1: w = 32'((fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                 | (fld(imm, 4, 0) << 7) | 'h23);
      2, 3, 4, 5, 6:
         w = 32'((((kind == 3) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                 | (rd << 7) | 'h33);
      7: w = 32'((fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
                 | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 'h63);
      8, 9, 10, 11:
         w = 32'((fld(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13);
      12: w = 32'((fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                  | (fld(imm, 19, 12) << 12) | (rd << 7) | 'h6f);
      13: w = (imm & 32'hfffff000) | 32'((rd << 7) | 'h37);
      default: w = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mem_ready_i = 1'b1;
        1:       mem_ready_i = ($urandom_range(0, 2) != 0);
        default: mem_ready_i = 1'b0;
      endcase
    end
  end

  logic          stall_prev = 1'b0;
  logic [AW-1:0] stall_addr;
  logic [31:0]   stall_wd;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_we", 32'(mem_we_o), 32'd1);
        check("stall_addr", 32'(mem_addr_o), 32'(stall_addr));
        check("stall_wd", mem_wd_o, stall_wd);
      end
      if (mem_we_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr_o), 32'(mon_e.addr));
          check("write_wd", mem_wd_o, mon_e.word);
        end
        stall_prev = 1'b0;
      end else if (mem_we_o) begin
        stall_prev = 1'b1;
        stall_addr = mem_addr_o;
        stall_wd   = mem_wd_o;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    req_valid_i = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_addr  = 0;
    m_count = 0;
    m_err   = 1'b0;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wd", mem_wd_o, 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
  endtask

  task automatic issue(input int kind, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit known, input logic [31:0] known_w);
    bit          ok;
    logic [31:0] w;
    int          n = 0;
    while (!req_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready_o) fail_now("ready_timeout");
    ref_encode(kind, rd, rs1, rs2, imm, ok, w);
    if (known) begin
      ok = 1;
      w  = known_w;
    end
    if (ok) begin
      exp_q.push_back('{m_addr, w});
      m_addr = (m_addr + 1) % CAP;
      m_count++;
    end else begin
      m_err = 1'b1;
    end
    kind_i      = 4'(kind);
    rd_i        = 5'(rd);
    rs1_i       = 5'(rs1);
    rs2_i       = 5'(rs2);
    imm_i       = imm;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!(req_ready_o || full_o) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail_now("settle_timeout");
    check("count", 32'(count_o), 32'(m_count));
    check("err", 32'(err_o), 32'(m_err));
    check("full", 32'(full_o), 32'(m_count == CAP));
    check("pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int          kind, sel;
    logic [31:0] imm;
    tick();
    do_reset();

    issue(8, 1, 0, 0, 32'd5, 1, 32'h00500093);       settle();
    issue(3, 3, 1, 2, 32'd0, 1, 32'h402081B3);       settle();
    issue(7, 0, 1, 2, 32'd8, 1, 32'h00208463);       settle();
    do_reset();
    issue(12, 1, 0, 0, 32'd16, 1, 32'h010000EF);     settle();
    issue(13, 5, 0, 0, 32'h12345000, 1, 32'h123452B7); settle();

    // Hold mem_ready_i low: the pending write must freeze in place.
    rdy_mode = 2;
    issue(10, 7, 4, 0, 32'hffff_ff00, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_we", 32'(mem_we_o), 32'd1);
      check("hold_ready", 32'(req_ready_o), 32'd0);
      check("hold_count", 32'(count_o), 32'(m_count - 1));
    end
    rdy_mode = 0;
    settle();

    issue(2, 9, 10, 11, 32'd0, 0, 32'd0);            settle();
    kind_i      = 4'd8;
    imm_i       = 32'd1;
    req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_ready", 32'(req_ready_o), 32'd0);
      check("full_flag", 32'(full_o), 32'd1);
      check("full_count", 32'(count_o), 32'(CAP));
    end
    req_valid_i = 1'b0;
    do_reset();

    issue(8, 1, 0, 0, 32'd2048, 0, 32'd0);           settle();
    issue(7, 0, 1, 2, 32'd3, 0, 32'd0);              settle();
    issue(14, 1, 1, 1, 32'd0, 0, 32'd0);             settle();
    do_reset();

    rdy_mode = 2;
    issue(0, 2, 3, 0, 32'd12, 0, 32'd0);
    tick();
    tick();
    check("midwrite_we", 32'(mem_we_o), 32'd1);
    do_reset();

    rdy_mode = 1;
    for (int it = 0; it < 150; it++) begin
      if (m_count == CAP) do_reset();
      kind = $urandom_range(0, 15);
      sel  = $urandom_range(0, 5);
      case (sel)
        0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       imm = 32'(bnd[$urandom_range(0, 13)]);
        2:       imm = $urandom;
        3:       imm = $urandom & 32'hfffff000;
        4:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = 32'($urandom_range(0, (1 << 21) - 1)) - 32'(1 << 20);
      endcase
      issue(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, 0, 32'd0);
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
